// File: rtl/dispctl_dim.sv
// Multiplexed 7-segment display controller with PWM dimming.
// Frame-synchronous double buffering keeps content from tearing mid-frame.
module dispctl_dim #(
    parameter int NDIG  = 8,
    parameter int DIV   = 1000,
    parameter int BRT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   data,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blank,
    input  logic [BRT_W-1:0]    bright,
    input  logic                load,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic                frame
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = $clog2(DIV);

    localparam logic [IW-1:0]    IDX_LAST  = IW'(NDIG - 1);
    localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);
    localparam logic [BRT_W-1:0] PH_LAST   = '1;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Timebase: prescaler, PWM sub-slot and digit index
    logic [PW-1:0]    pcnt;
    logic [BRT_W-1:0] ph;
    logic [IW-1:0]    idx;

    logic tick;
    logic ph_wrap;
    logic boundary;

    // Pending (load-side) and active (display-side) buffers
    logic [4*NDIG-1:0] pend_data;
    logic [NDIG-1:0]   pend_dp;
    logic [NDIG-1:0]   pend_blank;

    logic [4*NDIG-1:0] act_data;
    logic [NDIG-1:0]   act_dp;
    logic [NDIG-1:0]   act_blank;
    logic [BRT_W-1:0]  act_bright;

    // Per-digit selection of the active buffer
    logic [3:0]      cur_nib;
    logic            cur_dp;
    logic            cur_blank;
    logic [NDIG-1:0] cur_sel;
    logic            pwm_on;
    logic            lit;

    // Active-low segment pattern, bit 0 = a through bit 6 = g
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0:    r = 7'b1000000;
            4'h1:    r = 7'b1111001;
            4'h2:    r = 7'b0100100;
            4'h3:    r = 7'b0110000;
            4'h4:    r = 7'b0011001;
            4'h5:    r = 7'b0010010;
            4'h6:    r = 7'b0000010;
            4'h7:    r = 7'b1111000;
            4'h8:    r = 7'b0000000;
            4'h9:    r = 7'b0010000;
            4'hA:    r = 7'b0001000;
            4'hB:    r = 7'b0000011;
            4'hC:    r = 7'b1000110;
            4'hD:    r = 7'b0100001;
            4'hE:    r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // Tick, sub-slot wrap and frame boundary decode from current counters
    always_comb begin
        tick     = (pcnt == PCNT_LAST);
        ph_wrap  = tick && (ph == PH_LAST);
        boundary = ph_wrap && (idx == IDX_LAST);
    end

    // Prescaler, sub-slot counter and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            ph   <= '0;
            idx  <= '0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                ph   <= ph + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (ph_wrap) begin
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Pending buffer: last load before a boundary wins
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
        end else if (load) begin
            pend_data  <= data;
            pend_dp    <= dp_in;
            pend_blank <= blank;
        end
    end

    // Active buffer: copies pending (pre-edge values) only at a boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_bright <= '0;
        end else if (boundary) begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_bright <= bright;
        end
    end

    // Pick the nibble, dp and blank bit of the digit being scanned
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_sel   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = act_data[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = act_blank[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

    // PWM gate: full-scale brightness keeps the digit on for every sub-slot
    always_comb begin
        pwm_on = (ph < act_bright) || (&act_bright);
        lit    = !cur_blank && pwm_on;
    end

    // Registered drive outputs, one cycle behind the counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            seg   <= SEG_OFF;
            dp    <= 1'b1;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (lit) begin
                seg <= hex7(cur_nib);
                dp  <= ~cur_dp;
                an  <= ~cur_sel;
            end else begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                an  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_dispctl_dim.sv
// Self-checking bench for dispctl_dim (NDIG=4, DIV=2, BRT_W=2).
// Directed vector table, multi-cycle sequences and a random run vs a frame model.
module tb_dispctl_dim;

    localparam int NDIG  = 4;
    localparam int DIV   = 2;
    localparam int BRT_W = 2;
    localparam int SUB   = 1 << BRT_W;
    localparam int SLOT  = SUB * DIV;
    localparam int FRAME = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [1:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    dispctl_dim #(.NDIG(NDIG), .DIV(DIV), .BRT_W(BRT_W)) dut (
        .clk(clk), .reset(reset), .data(data), .dp_in(dp_in),
        .blank(blank), .bright(bright), .load(load),
        .seg(seg), .dp(dp), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexcode(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: position within the frame from a plain cycle count
    int          n;
    logic [15:0] m_pdata, m_adata;
    logic [3:0]  m_pdp, m_adp, m_pblank, m_ablank;
    logic [1:0]  m_abright;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_frame;

    always @(posedge clk) begin
        int pos, d, s;
        bit lit;
        if (reset) begin
            n         <= 0;
            m_pdata   <= '0;
            m_adata   <= '0;
            m_pdp     <= '0;
            m_adp     <= '0;
            m_pblank  <= 4'hF;
            m_ablank  <= 4'hF;
            m_abright <= '0;
            e_seg     <= 7'h7F;
            e_dp      <= 1'b1;
            e_an      <= 4'hF;
            e_frame   <= 1'b0;
        end else begin
            pos = n % FRAME;
            d   = pos / SLOT;
            s   = (pos / DIV) % SUB;
            lit = !m_ablank[d] && ((s < int'(m_abright)) || (m_abright == 2'd3));
            e_an    <= lit ? ~(4'b0001 << d) : 4'hF;
            e_seg   <= lit ? hexcode(m_adata[4*d +: 4]) : 7'h7F;
            e_dp    <= lit ? ~m_adp[d] : 1'b1;
            e_frame <= (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                m_adata   <= m_pdata;
                m_adp     <= m_pdp;
                m_ablank  <= m_pblank;
                m_abright <= bright;
            end
            if (load) begin
                m_pdata  <= data;
                m_pdp    <= dp_in;
                m_pblank <= blank;
            end
            n <= n + 1;
        end
    end

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL model t=%0t got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b",
                             $time, an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic sync_pos(input int p);
        int k;
        k = 0;
        while (((n % FRAME) != p) && (k < 2 * FRAME)) begin
            @(negedge clk);
            k++;
        end
        check("sync_pos", int'((n % FRAME) == p), 1);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] b,
                              input logic [3:0] p, input logic [1:0] br);
        data   = d;
        blank  = b;
        dp_in  = p;
        bright = br;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic count_seg(input int cycles, input logic [6:0] pat, output int hits);
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (an !== 4'hF && seg === pat) hits++;
        end
    endtask

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       blank;
        logic [3:0]       dp_in;
        logic [1:0]       bright;
        logic [3:0][3:0]  lit;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpx;
    } vec_t;

    vec_t vt [7];

    initial begin
        int lit_seen, nfr, last, hits, old_seen, new_early, k;
        bit per_ok, got;
        int cnt [4];
        int run [4];
        int cur [4];
        bit segbad [4];
        bit dpbad [4];

        vt[0] = '{16'h80F0, 4'b0000, 4'b0000, 2'd3, {4'd8, 4'd8, 4'd8, 4'd8},
                  {7'h00, 7'h40, 7'h0E, 7'h40}, 4'b1111};
        vt[1] = '{16'h80F0, 4'b0000, 4'b0000, 2'd1, {4'd2, 4'd2, 4'd2, 4'd2},
                  {7'h00, 7'h40, 7'h0E, 7'h40}, 4'b1111};
        vt[2] = '{16'h80F0, 4'b0000, 4'b0000, 2'd0, {4'd0, 4'd0, 4'd0, 4'd0},
                  {7'h00, 7'h40, 7'h0E, 7'h40}, 4'b1111};
        vt[3] = '{16'h1234, 4'b0100, 4'b0001, 2'd3, {4'd8, 4'd0, 4'd8, 4'd8},
                  {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110};
        vt[4] = '{16'hABCD, 4'b0000, 4'b1010, 2'd2, {4'd4, 4'd4, 4'd4, 4'd4},
                  {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0101};
        vt[5] = '{16'h5679, 4'b1001, 4'b0000, 2'd3, {4'd0, 4'd8, 4'd8, 4'd0},
                  {7'h12, 7'h02, 7'h78, 7'h10}, 4'b1111};
        vt[6] = '{16'hE8E8, 4'b0000, 4'b0000, 2'd3, {4'd8, 4'd8, 4'd8, 4'd8},
                  {7'h06, 7'h00, 7'h06, 7'h00}, 4'b1111};

        reset  = 1'b1;
        load   = 1'b0;
        data   = '0;
        dp_in  = '0;
        blank  = '0;
        bright = '0;

        // Reset state on the first reset edge
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_an", int'(an), 4'hF);
        check("rst_seg", int'(seg), 7'h7F);
        check("rst_dp", int'(dp), 1);
        check("rst_frame", int'(frame), 0);
        @(negedge clk);
        reset = 1'b0;

        // No load: dark for 100 cycles, frame pulse every 32 cycles
        lit_seen = 0;
        nfr      = 0;
        last     = -1;
        per_ok   = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (an !== 4'hF) lit_seen++;
            if (frame === 1'b1) begin
                if (last >= 0 && (c - last) != FRAME) per_ok = 1'b0;
                if (last < 0 && c != FRAME - 1) per_ok = 1'b0;
                last = c;
                nfr++;
            end
        end
        check("dark100", lit_seen, 0);
        check("frame_period", int'(per_ok), 1);
        check("frame_count", nfr, 3);

        // Directed vector table: one full frame observed per vector
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            pulse_load(vt[v].data, vt[v].blank, vt[v].dp_in, vt[v].bright);
            repeat (2 * FRAME) @(negedge clk);
            sync_pos(0);
            for (int d = 0; d < 4; d++) begin
                cnt[d] = 0; run[d] = 0; cur[d] = 0;
                segbad[d] = 1'b0; dpbad[d] = 1'b0;
            end
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    if (an[d] === 1'b0) begin
                        cnt[d]++;
                        cur[d]++;
                        if (cur[d] > run[d]) run[d] = cur[d];
                        if (seg !== vt[v].seg[d]) segbad[d] = 1'b1;
                        if (dp !== vt[v].dpx[d]) dpbad[d] = 1'b1;
                    end else begin
                        cur[d] = 0;
                    end
                end
            end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("v%0d_d%0d_cnt", v, d), cnt[d], int'(vt[v].lit[d]));
                check($sformatf("v%0d_d%0d_run", v, d), run[d], int'(vt[v].lit[d]));
                check($sformatf("v%0d_d%0d_seg", v, d), int'(segbad[d]), 0);
                check($sformatf("v%0d_d%0d_dp", v, d), int'(dpbad[d]), 0);
            end
        end

        // Mid-frame load: old digits persist until the frame pulse
        sync_pos(10);
        pulse_load(16'h1111, 4'b0000, 4'b0000, 2'd3);
        old_seen  = 0;
        new_early = 0;
        k         = 0;
        got       = 1'b0;
        while (!got && k < FRAME + 8) begin
            @(negedge clk);
            k++;
            if (an !== 4'hF) begin
                if (seg === 7'h79) new_early++;
                else old_seen++;
            end
            if (frame === 1'b1) got = 1'b1;
        end
        check("midload_frame_seen", int'(got), 1);
        check("midload_no_early", new_early, 0);
        check("midload_old_seen", int'(old_seen > 0), 1);
        count_seg(FRAME, 7'h79, hits);
        check("midload_new", hits, FRAME);

        // Load on the boundary cycle: visible one frame later
        sync_pos(FRAME - 1);
        pulse_load(16'h2222, 4'b0000, 4'b0000, 2'd3);
        check("bndload_pulse", int'(frame), 1);
        count_seg(FRAME, 7'h79, hits);
        check("bndload_old_frame", hits, FRAME);
        count_seg(FRAME, 7'h24, hits);
        check("bndload_new_frame", hits, FRAME);

        // Reset mid-frame on a lit display discards the pending load
        sync_pos(12);
        pulse_load(16'h3333, 4'b0000, 4'b0000, 2'd3);
        sync_pos(18);
        check("prereset_lit", int'(an !== 4'hF), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_an", int'(an), 4'hF);
        check("midrst_seg", int'(seg), 7'h7F);
        check("midrst_dp", int'(dp), 1);
        check("midrst_frame", int'(frame), 0);
        reset = 1'b0;
        lit_seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (an !== 4'hF) lit_seen++;
        end
        check("dark_after_reset", lit_seen, 0);

        // Randomised traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 7) == 0);
            data  = 16'($urandom);
            dp_in = 4'($urandom);
            blank = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bright = 2'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
